// File: rtl/env_voice_sched.sv
// env_voice_sched: voice scheduler for a bank of envelope generators.
//
// Divides the system clock by 2^PRE_W to form the envelope clock. Accepts note-on
// requests over a valid/ready handshake and gives each note to the lowest-index free
// voice. The chosen voice's clear is held across one envelope clock rise, so the
// envelope starts cleanly. The scheduler tracks a per-voice age in envelope ticks and
// reports busy/free from it.
//
// Optional feature macro: STEAL_EN
//   defined   - when every voice is busy, the oldest voice is reused and o_steal pulses
//   undefined - o_note_ready stays low while every voice is busy; o_steal is tied to 0
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_note_valid   note-on request
//   i_note_key     key of the request, captured on accept
//   o_note_ready   scheduler can accept a request this cycle
//   o_env_clk      envelope clock to all voices (prescaler MSB)
//   o_voice_clr    per-voice envelope clear, at most one bit high
//   o_voice_key    key held by each voice, voice v at [v*NOTE_W +: NOTE_W]
//   o_voice_busy   per-voice envelope still running
//   o_steal        one-cycle pulse when an allocation reused a busy voice

`ifndef CLK_FREQ
`define CLK_FREQ 50000000
`endif

module env_voice_sched #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned NOTE_W     = 7,
  parameter int unsigned PRE_W      = 16,
  parameter int unsigned ENV_TICKS  = 3 * (`CLK_FREQ / 65536)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_note_valid,
  input  logic [NOTE_W-1:0]            i_note_key,
  output logic                         o_note_ready,
  output logic                         o_env_clk,
  output logic [NUM_VOICES-1:0]        o_voice_clr,
  output logic [NUM_VOICES*NOTE_W-1:0] o_voice_key,
  output logic [NUM_VOICES-1:0]        o_voice_busy,
  output logic                         o_steal
);

  localparam int unsigned VIdxW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [15:0] AgeMax = 16'(ENV_TICKS - 1);
  // Last cycle before the envelope clock rises.
  localparam logic [PRE_W-1:0] PreRise = {1'b0, {(PRE_W-1){1'b1}}};
  // Three quarters through the prescaler period: well after the rise, before the fall.
  localparam logic [PRE_W-1:0] PreExit = {2'b11, {(PRE_W-2){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAlloc, StArm} state_e;

  state_e                  r_state, w_state_d;
  logic [PRE_W-1:0]        r_pre;
  logic [NOTE_W-1:0]       r_key_lat;
  logic                    r_lo_seen;
  logic [NUM_VOICES-1:0]   r_clr;
  logic [NOTE_W-1:0]       r_key [NUM_VOICES];
  logic [15:0]             r_age [NUM_VOICES];
  logic [NUM_VOICES-1:0]   r_busy;

  logic                    w_rise;
  logic                    w_free_found;
  logic [VIdxW-1:0]        w_free_idx;
  logic [VIdxW-1:0]        w_alloc_idx;
  logic [NUM_VOICES-1:0]   w_alloc_oh;
  logic                    w_can_accept;
  logic                    w_steal_sel;
  logic                    w_accept;
  logic                    w_arm_exit;
  logic [15:0]             w_age_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]   w_busy_d;

  assign w_rise       = (r_pre == PreRise);
  assign o_env_clk    = r_pre[PRE_W-1];
  assign o_voice_clr  = r_clr;
  assign o_voice_busy = r_busy;

  // Lowest-index free voice, based on the registered busy flags.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = VIdxW'(i);
      end
    end
  end

`ifdef STEAL_EN
  logic [VIdxW-1:0] w_old_idx;

  // Oldest voice; strict compare keeps ties on the lowest index.
  always_comb begin
    w_old_idx = '0;
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (r_age[i] > r_age[w_old_idx]) begin
        w_old_idx = VIdxW'(i);
      end
    end
  end

  assign w_can_accept = 1'b1;
  assign w_steal_sel  = !w_free_found;
  assign w_alloc_idx  = w_free_found ? w_free_idx : w_old_idx;
`else
  assign w_can_accept = w_free_found;
  assign w_steal_sel  = 1'b0;
  assign w_alloc_idx  = w_free_idx;
`endif

  always_comb begin
    w_alloc_oh              = '0;
    w_alloc_oh[w_alloc_idx] = 1'b1;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    w_state_d    = r_state;
    o_note_ready = 1'b0;
    o_steal      = 1'b0;
    w_accept     = 1'b0;
    w_arm_exit   = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_note_ready = w_can_accept;
        if (i_note_valid && w_can_accept) begin
          w_accept  = 1'b1;
          w_state_d = StAlloc;
        end
      end
      StAlloc: begin
        o_steal   = w_steal_sel;
        w_state_d = StArm;
      end
      StArm: begin
        // lo_seen proves the rise inside this ARM window has already happened.
        if ((r_pre == PreExit) && r_lo_seen) begin
          w_arm_exit = 1'b1;
          w_state_d  = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Age advance with saturation; the voice being armed stays pinned at zero so its
  // age matches the envelope counter that is being held in clear.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_age_d[v] = r_age[v];
      if (w_rise && (r_age[v] != AgeMax)) begin
        w_age_d[v] = r_age[v] + 16'd1;
      end
      if (((r_state == StAlloc) && w_alloc_oh[v]) || ((r_state == StArm) && r_clr[v])) begin
        w_age_d[v] = '0;
      end
      w_busy_d[v] = (w_age_d[v] != AgeMax);
    end
  end

  always_comb begin
    o_voice_key = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      o_voice_key[v*NOTE_W +: NOTE_W] = r_key[v];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_pre     <= '0;
      r_key_lat <= '0;
      r_lo_seen <= 1'b0;
      r_clr     <= '0;
      r_busy    <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_key[v] <= '0;
        r_age[v] <= AgeMax;
      end
    end else begin
      r_state <= w_state_d;
      r_pre   <= r_pre + 1'b1;
      r_busy  <= w_busy_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_age[v] <= w_age_d[v];
      end
      if (w_accept) begin
        r_key_lat <= i_note_key;
      end
      if (r_state == StAlloc) begin
        r_key[w_alloc_idx] <= r_key_lat;
        r_clr              <= w_alloc_oh;
        r_lo_seen          <= 1'b0;
      end
      if (r_state == StArm) begin
        if (!r_pre[PRE_W-1]) begin
          r_lo_seen <= 1'b1;
        end
        if (w_arm_exit) begin
          r_clr <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_env_voice_sched.sv
// Directed bench for env_voice_sched with PRE_W=4, ENV_TICKS=5, four voices.
// pc tracks the prescaler value since the last reset release; every expected value
// below is hand-derived from that count (rise at pre 7, ARM exit at pre 12).
module tb_env_voice_sched;
  localparam int unsigned NV = 4;
  localparam int unsigned NW = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              note_valid = 1'b0;
  logic [NW-1:0]     note_key = '0;
  logic              note_ready;
  logic              env_clk;
  logic [NV-1:0]     voice_clr;
  logic [NV*NW-1:0]  voice_key;
  logic [NV-1:0]     voice_busy;
  logic              steal;

  int n_vec = 0;
  int n_err = 0;
  int pc = 0;
  int rst_at = 0;
  logic [NV-1:0] clr_arm = '0;

  env_voice_sched #(
    .NUM_VOICES (NV),
    .NOTE_W     (NW),
    .PRE_W      (4),
    .ENV_TICKS  (5)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_note_valid (note_valid),
    .i_note_key   (note_key),
    .o_note_ready (note_ready),
    .o_env_clk    (env_clk),
    .o_voice_clr  (voice_clr),
    .o_voice_key  (voice_key),
    .o_voice_busy (voice_busy),
    .o_steal      (steal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @pc=%0d: observed %0h expected %0h", tag, pc, obs, exp);
    end
  endtask

  // Advance to prescaler count t; samples land 1 time unit after each rising edge.
  task automatic step_to(input int t);
    while (pc < t) begin
      @(posedge clk);
      #1;
      pc++;
    end
  endtask

  function automatic logic [NW-1:0] key_of(input int v);
    return voice_key[v*NW +: NW];
  endfunction

  initial begin
    // Power-on reset and reset values.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pc = 0;
    check("rst_env", 32'(env_clk), 32'd0);
    check("rst_clr", 32'(voice_clr), 32'h0);
    check("rst_busy", 32'(voice_busy), 32'h0);
    check("rst_ready", 32'(note_ready), 32'd1);
    check("rst_steal", 32'(steal), 32'd0);
    check("rst_keys", 32'(voice_key), 32'h0);
    for (int k = 1; k <= 16; k++) begin
      step_to(k);
      check("pre_env", 32'(env_clk), (k % 16 >= 8) ? 32'd1 : 32'd0);
    end
    pc = 0;

    // Single note, accepted at pre 0.
    note_valid = 1'b1;
    note_key = 7'd60;
    check("n1_ready", 32'(note_ready), 32'd1);
    step_to(1);
    note_valid = 1'b0;
    check("n1_alloc_ready", 32'(note_ready), 32'd0);
    check("n1_alloc_clr", 32'(voice_clr), 32'h0);
    check("n1_alloc_steal", 32'(steal), 32'd0);
    step_to(2);
    check("n1_clr_on", 32'(voice_clr), 32'h1);
    check("n1_key0", 32'(key_of(0)), 32'd60);
    check("n1_busy", 32'(voice_busy), 32'h1);
    step_to(12);
    check("n1_clr_last", 32'(voice_clr), 32'h1);
    step_to(13);
    check("n1_clr_off", 32'(voice_clr), 32'h0);
    check("n1_idle_ready", 32'(note_ready), 32'd1);
    step_to(71);
    check("n1_busy_before", 32'(voice_busy), 32'h1);
    step_to(72);
    check("n1_busy_clear", 32'(voice_busy), 32'h0);
    check("n1_key_persist", 32'(key_of(0)), 32'd60);

    // Fill the bank back to back.
    note_valid = 1'b1;
    note_key = 7'd60;
    step_to(73);
    check("f0_steal", 32'(steal), 32'd0);
    note_key = 7'd62;
    step_to(74);
    check("f0_clr", 32'(voice_clr), 32'h1);
    check("f0_key", 32'(key_of(0)), 32'd60);
    step_to(87);
    check("f0_env_lo", 32'(env_clk), 32'd0);
    check("f0_clr_pre_rise", 32'(voice_clr), 32'h1);
    step_to(88);
    check("f0_env_hi", 32'(env_clk), 32'd1);
    check("f0_clr_post_rise", 32'(voice_clr), 32'h1);
    step_to(93);
    check("f0_clr_off", 32'(voice_clr), 32'h0);
    check("f0_ready", 32'(note_ready), 32'd1);
    step_to(94);
    check("f1_steal", 32'(steal), 32'd0);
    note_key = 7'd64;
    step_to(95);
    check("f1_clr", 32'(voice_clr), 32'h2);
    check("f1_key", 32'(key_of(1)), 32'd62);
    step_to(109);
    check("f1_ready", 32'(note_ready), 32'd1);
    step_to(110);
    check("f2_steal", 32'(steal), 32'd0);
    note_key = 7'd67;
    step_to(111);
    check("f2_clr", 32'(voice_clr), 32'h4);
    check("f2_key", 32'(key_of(2)), 32'd64);
    step_to(125);
    check("f2_ready", 32'(note_ready), 32'd1);
    step_to(126);
    check("f3_steal", 32'(steal), 32'd0);
    note_key = 7'd72;
    step_to(127);
    check("f3_clr", 32'(voice_clr), 32'h8);
    check("f3_key", 32'(key_of(3)), 32'd67);
    check("f3_busy", 32'(voice_busy), 32'hF);
    step_to(141);
    check("full_busy", 32'(voice_busy), 32'hF);

`ifdef STEAL_EN
    // Fifth note steals voice 0 (age 3, the oldest).
    check("st_ready", 32'(note_ready), 32'd1);
    step_to(142);
    note_valid = 1'b0;
    check("st_pulse", 32'(steal), 32'd1);
    check("st_alloc_ready", 32'(note_ready), 32'd0);
    step_to(143);
    check("st_pulse_end", 32'(steal), 32'd0);
    check("st_clr", 32'(voice_clr), 32'h1);
    check("st_key0", 32'(key_of(0)), 32'd72);
    check("st_key1", 32'(key_of(1)), 32'd62);
    check("st_busy", 32'(voice_busy), 32'hF);
    rst_at = 152;
    clr_arm = 4'h1;
`else
    // Fifth note waits for voice 0 to expire.
    check("bp_ready_full", 32'(note_ready), 32'd0);
    step_to(151);
    check("bp_ready_hold", 32'(note_ready), 32'd0);
    check("bp_busy_hold", 32'(voice_busy), 32'hF);
    step_to(152);
    check("bp_busy_v0_free", 32'(voice_busy), 32'hE);
    check("bp_ready_go", 32'(note_ready), 32'd1);
    step_to(153);
    note_valid = 1'b0;
    check("bp_steal", 32'(steal), 32'd0);
    step_to(154);
    check("bp_clr", 32'(voice_clr), 32'h1);
    check("bp_key0", 32'(key_of(0)), 32'd72);
    step_to(173);
    check("bp_busy_v1_free", 32'(voice_busy), 32'hD);
    check("bp_idle_ready", 32'(note_ready), 32'd1);
    note_valid = 1'b1;
    note_key = 7'd50;
    step_to(174);
    note_valid = 1'b0;
    step_to(175);
    check("v1_clr", 32'(voice_clr), 32'h2);
    check("v1_key", 32'(key_of(1)), 32'd50);
    // Request raised in the cycle voice 2 expires; all voices still read busy.
    step_to(183);
    note_valid = 1'b1;
    note_key = 7'd77;
    check("sim_ready", 32'(note_ready), 32'd0);
    step_to(184);
    check("sim_busy", 32'(voice_busy), 32'hB);
    step_to(189);
    check("sim_ready_idle", 32'(note_ready), 32'd1);
    step_to(190);
    note_valid = 1'b0;
    check("sim_steal", 32'(steal), 32'd0);
    step_to(191);
    check("sim_clr", 32'(voice_clr), 32'h4);
    check("sim_key2", 32'(key_of(2)), 32'd77);
    check("sim_key1", 32'(key_of(1)), 32'd50);
    rst_at = 200;
    clr_arm = 4'h4;
`endif

    // Asynchronous reset in the middle of ARM, with env_clk high.
    step_to(rst_at);
    check("mid_env_hi", 32'(env_clk), 32'd1);
    check("mid_clr_hi", 32'(voice_clr), 32'(clr_arm));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_env", 32'(env_clk), 32'd0);
    check("mid_rst_clr", 32'(voice_clr), 32'h0);
    check("mid_rst_busy", 32'(voice_busy), 32'h0);
    check("mid_rst_keys", 32'(voice_key), 32'h0);
    check("mid_rst_ready", 32'(note_ready), 32'd1);
    @(posedge clk);
    #1;
    check("mid_rst_hold_env", 32'(env_clk), 32'd0);
    rst_n = 1'b1;
    pc = 0;
    for (int k = 1; k <= 9; k++) begin
      step_to(k);
      check("post_env", 32'(env_clk), (k >= 8) ? 32'd1 : 32'd0);
      check("post_ready", 32'(note_ready), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
